// File: rtl/plot_queue.sv
// Buffers processor plot requests and drains them, in order, into the 160x120x3 framebuffer write port; also runs full-screen clears.
// Latency: plot to fb_we is two edges with an empty FIFO; fb_ready low stalls drain/clear without losing state; plots into a full FIFO are dropped.
module plot_queue #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  color_draw,
    input  logic        plot,
    input  logic        clear,
    input  logic [2:0]  clear_color,
    input  logic        fb_ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [14:0] LAST_PIX = 15'(SCR_W * SCR_H - 1);

    state_t      state, state_nxt;
    logic [17:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          clear_pending;
    logic [2:0]    clear_col_q;
    logic [14:0]   counter;

    logic        empty;
    logic        in_range;
    logic [14:0] push_addr;
    logic        do_push, do_pop, do_drop, clear_go, clear_step;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign in_range = ({1'b0, x} < 9'(SCR_W)) && ({1'b0, y} < 9'(SCR_H));

    // y*160 as two shifts keeps the multiply out of the push path
    assign push_addr = ({7'd0, y} << 7) + ({7'd0, y} << 5) + {7'd0, x};

    assign do_push    = plot && in_range && !full;
    assign do_drop    = plot && (!in_range || full);
    assign do_pop     = (state == IDLE) && !empty && fb_ready;
    assign clear_go   = (state == IDLE) && clear_pending && empty;
    assign clear_step = (state == CLEAR) && fb_ready;

    assign busy = !empty || clear_pending || (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_go) state_nxt = CLEAR;
            CLEAR:   if (clear_step && counter == LAST_PIX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= {push_addr, color_draw};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            clear_pending <= 1'b0;
            clear_col_q   <= '0;
            counter       <= '0;
            fb_addr       <= '0;
            fb_data       <= '0;
            fb_we         <= 1'b0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            state <= state_nxt;

            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            // a clear request only registers when nothing else is queued up for clearing
            if (clear_go) begin
                clear_pending <= 1'b0;
            end else if (clear && !clear_pending && state == IDLE) begin
                clear_pending <= 1'b1;
                clear_col_q   <= clear_color;
            end

            if (clear_go)        counter <= '0;
            else if (clear_step) counter <= counter + 15'd1;

            fb_we <= 1'b0;
            if (do_pop) begin
                fb_addr <= mem[rptr][17:3];
                fb_data <= mem[rptr][2:0];
                fb_we   <= 1'b1;
            end else if (clear_step) begin
                fb_addr <= counter;
                fb_data <= clear_col_q;
                fb_we   <= 1'b1;
            end

            if (plot && in_range && full) overflow <= 1'b1;
            if (do_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule
